// File: rtl/occupancy_pkg.sv
// Shared types and helpers for the multi-channel occupancy tracker.
package occupancy_pkg;

   // Bits needed to hold the values 0..depth inclusive.
   function automatic int unsigned clog2_depth(input int unsigned depth);
      int unsigned w;
      w = 0;
      for (int unsigned i = 0; i < 32; i++) begin
         if ((64'd1 << i) <= 64'(depth)) w = i + 1;
      end
      return (w == 0) ? 1 : w;
   endfunction

   typedef struct packed {
      logic full;
      logic empty;
      logic almost_full;
      logic almost_empty;
      logic overflow_err;
      logic underflow_err;
   } occ_flags_t;

endpackage

// File: rtl/occupancy_channel.sv
// One saturating occupancy counter with registered level flags and sticky error bits.
module occupancy_channel
   import occupancy_pkg::*;
#(
   parameter int unsigned DEPTH         = 16,
   parameter int unsigned AFULL_THRESH  = 14,
   parameter int unsigned AEMPTY_THRESH = 2,
   localparam int unsigned CW           = clog2_depth(DEPTH)
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          increment,
   input  logic          decrement,
   input  logic          clear,
   input  logic          err_clear,
   output logic [CW-1:0] count,
   output occ_flags_t    flags
);

   if (DEPTH < 1) begin : g_bad_depth
      $fatal(1, "occupancy_channel: DEPTH must be >= 1");
   end
   if (AFULL_THRESH > DEPTH) begin : g_bad_afull
      $fatal(1, "occupancy_channel: AFULL_THRESH must be within 0..DEPTH");
   end
   if (AEMPTY_THRESH > DEPTH) begin : g_bad_aempty
      $fatal(1, "occupancy_channel: AEMPTY_THRESH must be within 0..DEPTH");
   end

   localparam logic [CW-1:0] DepthC   = CW'(DEPTH);
   localparam logic [CW-1:0] AfullTh  = CW'(AFULL_THRESH);
   localparam logic [CW-1:0] AemptyTh = CW'(AEMPTY_THRESH);

   localparam occ_flags_t FlagsRst = '{
      full:          1'b0,
      empty:         1'b1,
      almost_full:   (AFULL_THRESH == 0),
      almost_empty:  1'b1,
      overflow_err:  1'b0,
      underflow_err: 1'b0
   };

   logic [CW-1:0] count_q, count_d;
   occ_flags_t    flags_q, flags_d;
   logic          ovf_event, unf_event;

   always_comb begin
      count_d   = count_q;
      ovf_event = 1'b0;
      unf_event = 1'b0;
      if (clear) begin
         count_d = '0;
      end else if (increment && decrement) begin
         count_d = count_q;
      end else if (increment) begin
         if (count_q < DepthC) count_d = count_q + CW'(1);
         else                  ovf_event = 1'b1;
      end else if (decrement) begin
         if (count_q != '0) count_d = count_q - CW'(1);
         else               unf_event = 1'b1;
      end
   end

   // Flags are derived from the next count so they never lag the count output.
   always_comb begin
      flags_d               = FlagsRst;
      flags_d.full          = (count_d == DepthC);
      flags_d.empty         = (count_d == '0);
      flags_d.almost_full   = (count_d >= AfullTh);
      flags_d.almost_empty  = (count_d <= AemptyTh);
      // A fresh error beats a simultaneous err_clear.
      flags_d.overflow_err  = ovf_event | (flags_q.overflow_err & ~err_clear);
      flags_d.underflow_err = unf_event | (flags_q.underflow_err & ~err_clear);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         count_q <= '0;
         flags_q <= FlagsRst;
      end else begin
         count_q <= count_d;
         flags_q <= flags_d;
      end
   end

   assign count = count_q;
   assign flags = flags_q;

endmodule

// File: rtl/occupancy_tracker.sv
// Multi-channel occupancy tracker: NUM_CH independent channels with packed count output.
module occupancy_tracker
   import occupancy_pkg::*;
#(
   parameter int unsigned NUM_CH        = 4,
   parameter int unsigned DEPTH         = 16,
   parameter int unsigned AFULL_THRESH  = 14,
   parameter int unsigned AEMPTY_THRESH = 2,
   localparam int unsigned CW           = clog2_depth(DEPTH)
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic [NUM_CH-1:0]    increment,
   input  logic [NUM_CH-1:0]    decrement,
   input  logic [NUM_CH-1:0]    clear,
   input  logic                 err_clear,
   output logic [NUM_CH*CW-1:0] count,
   output logic [NUM_CH-1:0]    full,
   output logic [NUM_CH-1:0]    empty,
   output logic [NUM_CH-1:0]    almost_full,
   output logic [NUM_CH-1:0]    almost_empty,
   output logic [NUM_CH-1:0]    overflow_err,
   output logic [NUM_CH-1:0]    underflow_err
);

   if (NUM_CH < 1) begin : g_bad_num_ch
      $fatal(1, "occupancy_tracker: NUM_CH must be >= 1");
   end

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      occ_flags_t ch_flags;

      occupancy_channel #(
         .DEPTH         (DEPTH),
         .AFULL_THRESH  (AFULL_THRESH),
         .AEMPTY_THRESH (AEMPTY_THRESH)
      ) u_channel (
         .clock     (clock),
         .reset     (reset),
         .increment (increment[i]),
         .decrement (decrement[i]),
         .clear     (clear[i]),
         .err_clear (err_clear),
         .count     (count[i*CW +: CW]),
         .flags     (ch_flags)
      );

      assign full[i]          = ch_flags.full;
      assign empty[i]         = ch_flags.empty;
      assign almost_full[i]   = ch_flags.almost_full;
      assign almost_empty[i]  = ch_flags.almost_empty;
      assign overflow_err[i]  = ch_flags.overflow_err;
      assign underflow_err[i] = ch_flags.underflow_err;
   end

endmodule

// File: doc/occupancy_tracker.md
Name: occupancy_tracker

Overview:
Multi-channel, parametrised occupancy counter. It is the successor to the team's single 32-bit queue counter.
Each channel tracks the fill level of one downstream queue, with saturating arithmetic, registered full/empty and almost-full/almost-empty flags, per-channel clear, and sticky overflow/underflow error bits.
It sits beside the queue controllers and feeds back-pressure and credit logic.

Parameters:
NUM_CH, 4, number of independent channels (>=1)
DEPTH, 16, queue capacity per channel; count range 0..DEPTH (>=1)
AFULL_THRESH, 14, almost_full asserts when count >= AFULL_THRESH (0..DEPTH)
AEMPTY_THRESH, 2, almost_empty asserts when count <= AEMPTY_THRESH (0..DEPTH)
CW (localparam), $clog2(DEPTH+1), count width per channel

Ports:
clock  input  1  single clock, rising edge
reset  input  1  synchronous, active-high reset
increment  input  NUM_CH  per-channel push event
decrement  input  NUM_CH  per-channel pop event
clear  input  NUM_CH  per-channel synchronous count clear
err_clear  input  1  clears all sticky error bits
count  output  NUM_CH*CW  packed counts; channel i occupies bits [i*CW +: CW]
full  output  NUM_CH  count == DEPTH
empty  output  NUM_CH  count == 0
almost_full  output  NUM_CH  count >= AFULL_THRESH
almost_empty  output  NUM_CH  count <= AEMPTY_THRESH
overflow_err  output  NUM_CH  sticky: increment rejected at full
underflow_err  output  NUM_CH  sticky: decrement rejected at empty

Behaviour:
- Reset state: reset is synchronous and active-high, sampled on the rising clock edge. On reset:
  - count = 0, empty = 1, almost_empty = 1, full = 0.
  - almost_full = 1 only if AFULL_THRESH == 0, else 0.
  - overflow_err = 0, underflow_err = 0.
  - Reset overrides all other inputs.
- Latency: all outputs are registered. Events sampled at edge N appear on count and flags after edge N.
- Flag derivation: flags are computed from the next-count value, so flags always agree with the count output in the same cycle (no one-cycle flag lag).
- Per-channel priority, highest first:
  1. clear: count := 0. Increment and decrement are ignored; no error is raised.
  2. increment and decrement together: count unchanged, including at full and at 0; no error.
  3. increment only: if count < DEPTH then count + 1, else hold at DEPTH and set overflow_err.
  4. decrement only: if count > 0 then count - 1, else hold at 0 and set underflow_err.
  5. Neither: hold.
- Saturation: no wrap-around in either direction. Count never exceeds DEPTH and never goes below 0.
- Error bits:
  - Sticky until err_clear or reset.
  - If err_clear and a new error event occur in the same cycle, the error bit stays set (set wins).
  - clear does not touch error bits.
- Channel independence: channels are fully independent. Simultaneous events on different channels must not interact.
- Elaboration checks: DEPTH >= 1, NUM_CH >= 1, both thresholds within 0..DEPTH. Violations are fatal at elaboration.

Decomposition:
- Shared package occupancy_pkg holds:
  - count-width function clog2_depth(DEPTH).
  - typedef occ_flags_t, a struct of full, empty, almost_full, almost_empty, overflow_err, underflow_err.
- Sub-module occupancy_channel: one channel's counter, flags and error bits. Parameters DEPTH, AFULL_THRESH, AEMPTY_THRESH.
- Top level: generate loop over NUM_CH instances of occupancy_channel plus output packing.

Test Plan:
- Reset check: assert reset for 2 cycles with increment = all ones. Required: count = 0, empty = 4'b1111, almost_empty = 4'b1111, full = 0, errors = 0.
- Fill to saturation: ch0 increment for 18 cycles (DEPTH = 16). Required:
  - almost_full rises in the same cycle count reads 14.
  - full rises when count reads 16.
  - count holds at 16.
  - overflow_err[0] = 1 after the 17th increment.
  - ch1..3 stay at 0.
- Drain past empty: from count 3 on ch2, decrement for 5 cycles. Required:
  - count sequence 2, 1, 0, 0, 0.
  - almost_empty stays 1 throughout.
  - empty = 1 from the third cycle.
  - underflow_err[2] = 1 after the 4th decrement.
- Simultaneous events:
  - ch1 at 16 and ch3 at 0, each with increment = decrement = 1 for 3 cycles. Required: counts stay 16 and 0, no error bits.
  - ch0 at 5 with clear, increment and decrement all high. Required: count = 0 next cycle.
- Error clear race: overflow_err[0] set; next cycle err_clear = 1 while ch0 still gets increment at full. Required: overflow_err[0] stays 1. The following cycle, err_clear alone: overflow_err[0] = 0.
- Reset mid-operation: ch0..3 at 7, 16, 0, 9 with errors set; assert reset for one cycle while incrementing. Required: all counts 0, all errors 0, flags at reset values on the following cycle.
